mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Three-requester arbiter (loader, video, CPU) in front of a single-command memory backend.
// Loader has absolute priority; video and CPU alternate when both are waiting.
module mem_arbiter #(
  parameter int AW = 25
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ldr_wr,
  input  logic [AW-1:0] ldr_addr,
  input  logic [7:0]    ldr_data,
  output logic          ldr_busy,
  output logic          ldr_ovf,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_dout,
  output logic          vid_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout,
  input  logic          mem_ack
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic [1:0] {G_LDR = 2'd0, G_VID = 2'd1, G_CPU = 2'd2} gnt_t;

  state_t        r_state, w_state_nxt;
  gnt_t          r_gnt, w_gnt_nxt;
  logic          w_load, w_done;
  logic          w_ldr_clr, w_cpu_clr, w_vid_clr;
  logic          w_cmd_we;
  logic [AW-1:0] w_cmd_addr;
  logic [7:0]    w_cmd_din;

  logic          r_ldr_pend, r_ldr_ovf;
  logic [AW-1:0] r_ldr_addr;
  logic [7:0]    r_ldr_data;
  logic          r_cpu_pend, r_cpu_we;
  logic [AW-1:0] r_cpu_addr;
  logic [7:0]    r_cpu_din;
  logic          r_vid_pend;
  logic [AW-1:0] r_vid_addr;
  logic          r_last_vid;

  logic          r_mem_req, r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [7:0]    r_mem_din;
  logic          r_cpu_ack, r_vid_ack;
  logic [7:0]    r_cpu_dout, r_vid_dout;

  // Grant selection in IDLE, completion detection in BUSY.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ldr_pend) begin
          w_load    = 1'b1;
          w_gnt_nxt = G_LDR;
        end else if (r_vid_pend && !(r_last_vid && r_cpu_pend)) begin
          w_load    = 1'b1;
          w_gnt_nxt = G_VID;
        end else if (r_cpu_pend) begin
          w_load    = 1'b1;
          w_gnt_nxt = G_CPU;
        end else begin
          w_load    = 1'b0;
        end
        if (w_load) begin
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Command mux from the slot being granted.
  always_comb begin
    w_cmd_we   = 1'b0;
    w_cmd_addr = '0;
    w_cmd_din  = 8'h00;
    case (w_gnt_nxt)
      G_LDR: begin
        w_cmd_we   = 1'b1;
        w_cmd_addr = r_ldr_addr;
        w_cmd_din  = r_ldr_data;
      end
      G_VID: begin
        w_cmd_we   = 1'b0;
        w_cmd_addr = r_vid_addr;
        w_cmd_din  = 8'h00;
      end
      G_CPU: begin
        w_cmd_we   = r_cpu_we;
        w_cmd_addr = r_cpu_addr;
        w_cmd_din  = r_cpu_din;
      end
      default: begin
        w_cmd_we   = 1'b0;
      end
    endcase
  end

  assign w_ldr_clr = w_done && (r_gnt == G_LDR);
  assign w_cpu_clr = w_done && (r_gnt == G_CPU);
  assign w_vid_clr = w_done && (r_gnt == G_VID);

  // FSM state and current grant.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_gnt   <= G_CPU;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  // Backend command register: loaded on grant, held until completion.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= 8'h00;
    end else if (w_load) begin
      r_mem_req  <= 1'b1;
      r_mem_we   <= w_cmd_we;
      r_mem_addr <= w_cmd_addr;
      r_mem_din  <= w_cmd_din;
    end else if (w_done) begin
      r_mem_req  <= 1'b0;
    end
  end

  // Video/CPU alternation record; loader grants leave it alone.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_last_vid <= 1'b0;
    end else if (w_load && (w_gnt_nxt == G_VID)) begin
      r_last_vid <= 1'b1;
    end else if (w_load && (w_gnt_nxt == G_CPU)) begin
      r_last_vid <= 1'b0;
    end
  end

  // Completion pulses and read-data latches.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_ack  <= 1'b0;
      r_vid_ack  <= 1'b0;
      r_cpu_dout <= 8'h00;
      r_vid_dout <= 8'h00;
    end else begin
      r_cpu_ack <= w_cpu_clr;
      r_vid_ack <= w_vid_clr;
      if (w_cpu_clr && !r_mem_we) r_cpu_dout <= mem_dout;
      if (w_vid_clr) r_vid_dout <= mem_dout;
    end
  end

  // Pending slots: a completing slot can accept a new request on the same edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ldr_pend <= 1'b0;
      r_ldr_ovf  <= 1'b0;
      r_ldr_addr <= '0;
      r_ldr_data <= 8'h00;
      r_cpu_pend <= 1'b0;
      r_cpu_we   <= 1'b0;
      r_cpu_addr <= '0;
      r_cpu_din  <= 8'h00;
      r_vid_pend <= 1'b0;
      r_vid_addr <= '0;
    end else begin
      if (ldr_wr && (!r_ldr_pend || w_ldr_clr)) begin
        r_ldr_pend <= 1'b1;
        r_ldr_addr <= ldr_addr;
        r_ldr_data <= ldr_data;
      end else if (ldr_wr) begin
        r_ldr_ovf  <= 1'b1;
      end else if (w_ldr_clr) begin
        r_ldr_pend <= 1'b0;
      end
      if (cpu_req && (!r_cpu_pend || w_cpu_clr)) begin
        r_cpu_pend <= 1'b1;
        r_cpu_we   <= cpu_we;
        r_cpu_addr <= cpu_addr;
        r_cpu_din  <= cpu_din;
      end else if (w_cpu_clr) begin
        r_cpu_pend <= 1'b0;
      end
      if (vid_req && (!r_vid_pend || w_vid_clr)) begin
        r_vid_pend <= 1'b1;
        r_vid_addr <= vid_addr;
      end else if (w_vid_clr) begin
        r_vid_pend <= 1'b0;
      end
    end
  end

  assign ldr_busy = r_ldr_pend;
  assign ldr_ovf  = r_ldr_ovf;
  assign cpu_dout = r_cpu_dout;
  assign cpu_ack  = r_cpu_ack;
  assign vid_dout = r_vid_dout;
  assign vid_ack  = r_vid_ack;
  assign mem_req  = r_mem_req;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven and outputs checked on the falling clock edge,
// with the backend response played by hand.
module tb_mem_arbiter;
  localparam int AW = 25;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          ldr_wr = 1'b0;
  logic [AW-1:0] ldr_addr = '0;
  logic [7:0]    ldr_data = 8'h00;
  logic          ldr_busy, ldr_ovf;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_din = 8'h00;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [7:0]    vid_dout;
  logic          vid_ack;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout = 8'h00;
  logic          mem_ack = 1'b0;

  int total = 0;
  int bad = 0;

  mem_arbiter #(.AW(AW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_data(ldr_data),
    .ldr_busy(ldr_busy), .ldr_ovf(ldr_ovf),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick;
    @(negedge clk_sys);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise mem_ack after 'dly' falling edges, hold it for exactly one rising edge.
  task automatic serve(input int dly, input logic [7:0] d);
    repeat (dly) tick();
    mem_dout = d;
    mem_ack  = 1'b1;
    tick();
    mem_ack  = 1'b0;
  endtask

  task automatic cpu_pulse(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    tick();
    cpu_req = 1'b0;
  endtask

  initial begin
    // reset
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 25'h0);
    chk("rst_ldr_busy", ldr_busy, 1'b0);
    chk("rst_ldr_ovf", ldr_ovf, 1'b0);
    chk("rst_cpu_dout", cpu_dout, 8'h00);
    chk("rst_vid_dout", vid_dout, 8'h00);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // uncontended CPU read
    cpu_pulse(1'b0, 25'h0001234, 8'h00);
    chk("rd_req_edge1", mem_req, 1'b0);
    tick();
    chk("rd_req_edge2", mem_req, 1'b1);
    chk("rd_addr", mem_addr, 25'h0001234);
    chk("rd_we", mem_we, 1'b0);
    chk("rd_ack_early", cpu_ack, 1'b0);
    serve(2, 8'hA5);
    chk("rd_ack", cpu_ack, 1'b1);
    chk("rd_dout", cpu_dout, 8'hA5);
    chk("rd_req_drop", mem_req, 1'b0);
    tick();
    chk("rd_ack_single", cpu_ack, 1'b0);
    chk("rd_idle", mem_req, 1'b0);

    // contention: loader, video, CPU
    ldr_wr = 1'b1; ldr_addr = 25'h1ABCDEF; ldr_data = 8'h5A;
    vid_req = 1'b1; vid_addr = 25'h0000100;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h1FFFFFF; cpu_din = 8'hC3;
    tick();
    ldr_wr = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
    tick();
    chk("c_ldr_addr", mem_addr, 25'h1ABCDEF);
    chk("c_ldr_we", mem_we, 1'b1);
    chk("c_ldr_din", mem_din, 8'h5A);
    chk("c_ldr_busy", ldr_busy, 1'b1);
    serve(0, 8'h00);
    chk("c_ldr_busy_fall", ldr_busy, 1'b0);
    chk("c_ldr_noack_c", cpu_ack, 1'b0);
    chk("c_ldr_noack_v", vid_ack, 1'b0);
    chk("c_gap", mem_req, 1'b0);
    tick();
    chk("c_vid_req", mem_req, 1'b1);
    chk("c_vid_addr", mem_addr, 25'h0000100);
    chk("c_vid_we", mem_we, 1'b0);
    serve(0, 8'h77);
    chk("c_vid_ack", vid_ack, 1'b1);
    chk("c_vid_dout", vid_dout, 8'h77);
    tick();
    chk("c_cpu_addr", mem_addr, 25'h1FFFFFF);
    chk("c_cpu_we", mem_we, 1'b1);
    chk("c_cpu_din", mem_din, 8'hC3);
    vid_req = 1'b1; vid_addr = 25'h0000200;
    tick();
    vid_req = 1'b0;
    mem_dout = 8'h99; mem_ack = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0000300;
    tick();
    mem_ack = 1'b0; cpu_req = 1'b0;
    chk("c_wr_ack", cpu_ack, 1'b1);
    chk("c_wr_keep_dout", cpu_dout, 8'hA5);
    chk("c_wr_gap", mem_req, 1'b0);
    tick();
    chk("c_vid2_addr", mem_addr, 25'h0000200);
    serve(0, 8'h44);
    chk("c_vid2_dout", vid_dout, 8'h44);
    tick();
    chk("c_cpu2_addr", mem_addr, 25'h0000300);
    chk("c_cpu2_we", mem_we, 1'b0);
    serve(0, 8'h66);
    chk("c_cpu2_dout", cpu_dout, 8'h66);
    tick();
    chk("c_done_idle", mem_req, 1'b0);

    // new CPU pulse on the completion cycle of the previous CPU access
    cpu_pulse(1'b0, 25'h0000400, 8'h00);
    tick();
    chk("s_req", mem_req, 1'b1);
    mem_dout = 8'h5C; mem_ack = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0000500;
    tick();
    mem_ack = 1'b0; cpu_req = 1'b0;
    chk("s_ack", cpu_ack, 1'b1);
    chk("s_dout", cpu_dout, 8'h5C);
    chk("s_gap", mem_req, 1'b0);
    tick();
    chk("s_reissue", mem_req, 1'b1);
    chk("s_reissue_addr", mem_addr, 25'h0000500);
    chk("s_ack_single", cpu_ack, 1'b0);
    serve(0, 8'h3D);
    chk("s_dout2", cpu_dout, 8'h3D);
    tick();

    // loader overflow
    ldr_wr = 1'b1; ldr_addr = 25'h0000010; ldr_data = 8'h11;
    tick();
    ldr_addr = 25'h0000020; ldr_data = 8'h22;
    tick();
    ldr_wr = 1'b0;
    chk("o_req", mem_req, 1'b1);
    chk("o_addr", mem_addr, 25'h0000010);
    chk("o_din", mem_din, 8'h11);
    chk("o_ovf", ldr_ovf, 1'b1);
    serve(0, 8'h00);
    chk("o_busy_fall", ldr_busy, 1'b0);
    tick();
    chk("o_no_second", mem_req, 1'b0);
    tick();
    chk("o_ovf_sticky", ldr_ovf, 1'b1);

    // stray mem_ack while idle
    mem_ack = 1'b1; mem_dout = 8'hEE;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("i_cpu_ack", cpu_ack, 1'b0);
    chk("i_vid_ack", vid_ack, 1'b0);
    chk("i_req", mem_req, 1'b0);
    chk("i_cpu_dout", cpu_dout, 8'h3D);

    // stalled backend with new pulses arriving
    cpu_pulse(1'b1, 25'h00ABCDE, 8'hE1);
    tick();
    chk("st_req", mem_req, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin ldr_wr = 1'b1; ldr_addr = 25'h0000055; ldr_data = 8'h12; end
      if (i == 10) begin vid_req = 1'b1; vid_addr = 25'h0000066; end
      if (i == 15) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0000077; end
      tick();
      ldr_wr = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
      chk("st_addr", mem_addr, 25'h00ABCDE);
      chk("st_we", mem_we, 1'b1);
      chk("st_din", mem_din, 8'hE1);
    end
    serve(0, 8'h00);
    chk("st_ack", cpu_ack, 1'b1);
    chk("st_dout_keep", cpu_dout, 8'h3D);
    tick();
    chk("st_ldr_addr", mem_addr, 25'h0000055);
    chk("st_ldr_din", mem_din, 8'h12);
    serve(0, 8'h00);
    tick();
    chk("st_vid_addr", mem_addr, 25'h0000066);
    serve(0, 8'h88);
    chk("st_vid_dout", vid_dout, 8'h88);
    tick();
    chk("st_cpu_dropped", mem_req, 1'b0);

    // reset in the middle of an access
    cpu_pulse(1'b0, 25'h0000123, 8'h00);
    tick();
    chk("r_req", mem_req, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("r_async_req", mem_req, 1'b0);
    chk("r_async_addr", mem_addr, 25'h0);
    chk("r_async_ovf", ldr_ovf, 1'b0);
    chk("r_async_cdout", cpu_dout, 8'h00);
    chk("r_async_vdout", vid_dout, 8'h00);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    mem_ack = 1'b1; mem_dout = 8'hFF;
    tick();
    mem_ack = 1'b0;
    chk("r_cpu_ack", cpu_ack, 1'b0);
    chk("r_vid_ack", vid_ack, 1'b0);
    chk("r_req_after", mem_req, 1'b0);
    chk("r_cdout_after", cpu_dout, 8'h00);
    tick();
    chk("r_cpu_ack2", cpu_ack, 1'b0);
    chk("r_busy_after", ldr_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
